// File: rtl/l2_miss_ctrl_pkg.sv
// Shared L2 cache types: index/tag/line/way widths and the miss sequencer states.
package lc3b_types;

   typedef logic [3:0]   lc3b_c_l2_index;
   typedef logic [7:0]   lc3b_l2_tag;
   typedef logic [127:0] lc3b_l2_line;
   typedef logic [1:0]   lc3b_l2_way;

   typedef enum logic [2:0] {
      MS_IDLE,
      MS_CHECK,
      MS_WB,
      MS_FETCH,
      MS_FILL,
      MS_DONE
   } l2_miss_state_t;

endpackage

// File: rtl/l2_miss_ctrl_sat_counter.sv
// Saturating event counter: counts inc strobes and sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Increment on strobe unless already at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/l2_miss_ctrl.sv
// L2 miss/replacement sequencer: optional dirty-victim writeback, line fetch,
// fill into the victim way and pseudo-LRU update, plus miss/writeback counters.
module l2_miss_ctrl
   import lc3b_types::*;
#(
   parameter int LINE_W = 128,
   parameter int ADDR_W = 16,
   parameter int TAG_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic [1:0]        plru_way,
   input  logic [3:0]        way_valid,
   input  logic [3:0]        way_dirty,
   input  logic [TAG_W-1:0]  victim_tag,
   input  logic [LINE_W-1:0] victim_data,
   output logic [1:0]        victim_way,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              fill_we,
   output logic [3:0]        fill_index,
   output logic [TAG_W-1:0]  fill_tag,
   output logic [LINE_W-1:0] fill_data,
   output logic              plru_write,
   output logic [1:0]        plru_in,
   output logic              miss_done,
   output logic              busy,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  wb_count
);

   l2_miss_state_t    state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] line_q;
   lc3b_c_l2_index    idx;
   logic [TAG_W-1:0]  tag;
   logic              wb_inc;
   logic              miss_inc;

   assign idx = addr_q[7:4];
   assign tag = addr_q[ADDR_W-1:8];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= MS_IDLE;
      else
         state <= state_nxt;
   end

   // Capture request address and victim way in IDLE; capture fetched line on response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         victim_way <= '0;
         line_q     <= '0;
      end else begin
         if ((state == MS_IDLE) && miss_req) begin
            addr_q     <= miss_addr;
            victim_way <= plru_way;
         end
         if ((state == MS_FETCH) && pmem_resp)
            line_q <= pmem_rdata;
      end
   end

   // Next-state and per-state outputs; everything idles at zero.
   always_comb begin
      state_nxt    = state;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      fill_we      = 1'b0;
      fill_index   = '0;
      fill_tag     = '0;
      fill_data    = '0;
      plru_write   = 1'b0;
      plru_in      = '0;
      miss_done    = 1'b0;
      wb_inc       = 1'b0;
      miss_inc     = 1'b0;
      busy         = (state != MS_IDLE);
      unique case (state)
         MS_IDLE: begin
            if (miss_req)
               state_nxt = MS_CHECK;
         end
         MS_CHECK: begin
            // An invalid way never needs writing back, whatever its dirty bit says.
            if (way_valid[victim_way] && way_dirty[victim_way])
               state_nxt = MS_WB;
            else
               state_nxt = MS_FETCH;
         end
         MS_WB: begin
            pmem_write   = 1'b1;
            pmem_address = {victim_tag, idx, 4'b0000};
            pmem_wdata   = victim_data;
            if (pmem_resp) begin
               wb_inc    = 1'b1;
               state_nxt = MS_FETCH;
            end
         end
         MS_FETCH: begin
            pmem_read    = 1'b1;
            pmem_address = {tag, idx, 4'b0000};
            if (pmem_resp)
               state_nxt = MS_FILL;
         end
         MS_FILL: begin
            fill_we    = 1'b1;
            fill_index = idx;
            fill_tag   = tag;
            fill_data  = line_q;
            plru_write = 1'b1;
            plru_in    = victim_way;
            state_nxt  = MS_DONE;
         end
         MS_DONE: begin
            miss_done = 1'b1;
            miss_inc  = 1'b1;
            state_nxt = MS_IDLE;
         end
         default: state_nxt = MS_IDLE;
      endcase
   end

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (miss_inc),
      .count (miss_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wb_inc),
      .count (wb_count)
   );

endmodule

// File: tb/tb_l2_miss_ctrl.sv
// Scoreboard bench for l2_miss_ctrl; a narrow-counter copy shares the stimulus
// so saturation can be reached in a few dozen misses.
module tb_l2_miss_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         miss_req = 1'b0;
   logic [15:0]  miss_addr = '0;
   logic [1:0]   plru_way = '0;
   logic [3:0]   way_valid = '0;
   logic [3:0]   way_dirty = '0;
   logic [7:0]   victim_tag = '0;
   logic [127:0] victim_data = '0;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   logic [1:0]   victim_way, plru_in;
   logic         pmem_read, pmem_write, fill_we, plru_write, miss_done, busy;
   logic [15:0]  pmem_address, miss_count, wb_count;
   logic [127:0] pmem_wdata, fill_data;
   logic [3:0]   fill_index;
   logic [7:0]   fill_tag;

   logic [1:0]   victim_way_s, plru_in_s;
   logic         pmem_read_s, pmem_write_s, fill_we_s, plru_write_s, miss_done_s, busy_s;
   logic [15:0]  pmem_address_s;
   logic [3:0]   miss_count_s, wb_count_s;
   logic [127:0] pmem_wdata_s, fill_data_s;
   logic [3:0]   fill_index_s;
   logic [7:0]   fill_tag_s;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_miss = 0;
   int exp_wb   = 0;
   int exp_fills = 0;
   int fills_seen = 0;

   typedef struct {
      logic [3:0]   idx;
      logic [7:0]   tag;
      logic [127:0] data;
      logic [1:0]   way;
   } fill_t;
   fill_t exp_q[$];

   always #5 clk = ~clk;

   l2_miss_ctrl #(.LINE_W(128), .ADDR_W(16), .TAG_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
      .plru_way(plru_way), .way_valid(way_valid), .way_dirty(way_dirty),
      .victim_tag(victim_tag), .victim_data(victim_data), .victim_way(victim_way),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag),
      .fill_data(fill_data), .plru_write(plru_write), .plru_in(plru_in),
      .miss_done(miss_done), .busy(busy), .miss_count(miss_count), .wb_count(wb_count)
   );

   l2_miss_ctrl #(.LINE_W(128), .ADDR_W(16), .TAG_W(8), .CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
      .plru_way(plru_way), .way_valid(way_valid), .way_dirty(way_dirty),
      .victim_tag(victim_tag), .victim_data(victim_data), .victim_way(victim_way_s),
      .pmem_read(pmem_read_s), .pmem_write(pmem_write_s), .pmem_address(pmem_address_s),
      .pmem_wdata(pmem_wdata_s), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .fill_we(fill_we_s), .fill_index(fill_index_s), .fill_tag(fill_tag_s),
      .fill_data(fill_data_s), .plru_write(plru_write_s), .plru_in(plru_in_s),
      .miss_done(miss_done_s), .busy(busy_s), .miss_count(miss_count_s), .wb_count(wb_count_s)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat4(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   function automatic int sat16(input int n);
      return (n > 65535) ? 65535 : n;
   endfunction

   // Fill / PLRU scoreboard: every fill must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && (fill_we || plru_write)) begin
         fills_seen++;
         if (exp_q.size() == 0) begin
            chk("fill_unexp", fill_we | plru_write, 1'b0);
         end else begin
            fill_t e;
            e = exp_q.pop_front();
            chk("fill_we",    fill_we, 1'b1);
            chk("plru_write", plru_write, 1'b1);
            chk("fill_index", fill_index, e.idx);
            chk("fill_tag",   fill_tag, e.tag);
            chk("fill_data",  fill_data, e.data);
            chk("plru_in",    plru_in, e.way);
         end
      end
   end

   // Read and write requests must never overlap.
   always @(negedge clk) begin
      chk("rw_overlap", pmem_read & pmem_write, 1'b0);
   end

   task automatic check_counts(input string where);
      chk({where, "_miss_cnt"},   miss_count, sat16(exp_miss));
      chk({where, "_wb_cnt"},     wb_count, sat16(exp_wb));
      chk({where, "_miss_cnt_s"}, miss_count_s, sat4(exp_miss));
      chk({where, "_wb_cnt_s"},   wb_count_s, sat4(exp_wb));
   endtask

   task automatic do_miss(input logic [15:0] addr, input logic [1:0] way,
                          input logic [3:0] valid, input logic [3:0] dirty,
                          input logic [7:0] vtag, input logic [127:0] vdata,
                          input logic [127:0] rdata, input int wlat, input int rlat);
      logic        wb;
      logic [15:0] wb_a, rd_a;
      fill_t       f;
      wb   = valid[way] & dirty[way];
      wb_a = {vtag, addr[7:4], 4'h0};
      rd_a = {addr[15:4], 4'h0};
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      check_counts("idle");
      miss_req    = 1'b1;
      miss_addr   = addr;
      plru_way    = way;
      way_valid   = valid;
      way_dirty   = dirty;
      victim_tag  = vtag;
      victim_data = vdata;
      @(negedge clk);
      chk("check_busy", busy, 1'b1);
      chk("check_way", victim_way, way);
      chk("check_quiet", {pmem_read, pmem_write}, 2'b00);
      plru_way = ~way;
      @(negedge clk);
      if (wb) begin
         for (int i = 0; i <= wlat; i++) begin
            chk("wb_write", pmem_write, 1'b1);
            chk("wb_addr", pmem_address, wb_a);
            chk("wb_data", pmem_wdata, vdata);
            chk("wb_way", victim_way, way);
            if (i == wlat) pmem_resp = 1'b1;
            else plru_way = 2'($urandom_range(0, 3));
            @(negedge clk);
         end
         pmem_resp = 1'b0;
         exp_wb++;
      end
      for (int i = 0; i <= rlat; i++) begin
         chk("rd_read", pmem_read, 1'b1);
         chk("rd_addr", pmem_address, rd_a);
         chk("rd_way", victim_way, way);
         if (i == rlat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rdata;
            f.idx = addr[7:4]; f.tag = addr[15:8]; f.data = rdata; f.way = way;
            exp_q.push_back(f);
         end else begin
            plru_way = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
      end
      pmem_resp  = 1'b0;
      pmem_rdata = {4{$urandom}};
      chk("fill_cycle", fill_we, 1'b1);
      chk("fill_busy", busy, 1'b1);
      exp_fills++;
      @(negedge clk);
      // miss_req is still high here: DONE must not take it as a new miss.
      chk("done_pulse", miss_done, 1'b1);
      chk("done_nofill", fill_we, 1'b0);
      exp_miss++;
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_rw", {pmem_read, pmem_write}, 2'b00);
      chk("rst_addr", pmem_address, 16'h0);
      chk("rst_way", victim_way, 2'b00);
      chk("rst_fill", {fill_we, plru_write, miss_done}, 3'b000);
      check_counts("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // clean victim (way 2 invalid)
      do_miss(16'h3A50, 2'd2, 4'b0011, 4'b0000, 8'h11, {4{32'hDEADBEEF}}, {4{32'h0D0D0D0D}}, 0, 2);
      // dirty victim
      do_miss(16'h1230, 2'd1, 4'b0010, 4'b0010, 8'h7F, {4{32'hCAFEF00D}}, {4{32'h12345678}}, 1, 1);
      // slow memory on both phases
      do_miss(16'hC4E0, 2'd3, 4'b1000, 4'b1000, 8'hA5, {4{32'h5A5A1234}}, {4{32'h87654321}}, 20, 20);
      // invalid but dirty victim: no writeback
      do_miss(16'h5570, 2'd0, 4'b1110, 4'b0001, 8'h22, {4{32'h11112222}}, {4{32'h33334444}}, 0, 0);

      // reset in the middle of a fetch
      @(negedge clk);
      miss_req = 1'b0;
      @(negedge clk);
      miss_req = 1'b1; miss_addr = 16'h9990; plru_way = 2'd0;
      way_valid = 4'b0000; way_dirty = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      chk("rstf_read", pmem_read, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstf_busy", busy, 1'b0);
      chk("rstf_read0", pmem_read, 1'b0);
      chk("rstf_way", victim_way, 2'b00);
      exp_miss = 0;
      exp_wb   = 0;
      check_counts("rstf");
      miss_req = 1'b0;
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstf_idle", busy, 1'b0);
      check_counts("rstf_idle");

      // back-to-back dirty misses; narrow counters saturate
      for (int n = 0; n < 18; n++) begin
         do_miss(16'($urandom), 2'($urandom_range(0, 3)), 4'hF, 4'hF, 8'($urandom),
                 {4{$urandom}}, {4{$urandom}}, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      miss_req = 1'b0;
      @(negedge clk);
      chk("end_busy", busy, 1'b0);
      check_counts("end");
      chk("end_sat_s", miss_count_s, 4'hF);
      chk("fills_total", 32'(fills_seen), 32'(exp_fills));
      chk("fill_q_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
